uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the single UART transmitter between NUM_REQ byte requesters (monitor status, rx echo, debug).
// - Grants round-robin, honours CTS flow control and sequences the uart_tx start/busy handshake.
// - Detects a transmitter that never goes busy.
// - Sits in monitor_top between the requesters and uart_tx; the baud clock stays inside uart_tx.
// PARAMETERS
// - NUM_REQ       4     number of requesters, 2..8
// - DATA_W        8     byte width, equals `NUM_DATA_BITS
// - BUSY_TIMEOUT  4096  clk50 cycles allowed for tx_busy to rise after tx_start
// - MAX_BURST     16    bytes per grant in burst mode (only used with UART_TX_ARB_BURST_EN)
// PORTS
// - clk50       in   1                 50 MHz system clock
// - reset       in   1                 asynchronous, active-low reset
// - req_valid   in   NUM_REQ           requester i has a byte pending; held until acked
// - req_data    in   NUM_REQ*DATA_W    byte of requester i, slice [i*DATA_W +: DATA_W]
// - req_burst   in   NUM_REQ           requester i wants to keep the grant (burst build only)
// - req_ack     out  NUM_REQ           one-hot, 1-cycle pulse: byte of requester i accepted
// - tx_start    out  1                 1-cycle start pulse to uart_tx
// - tx_data     out  DATA_W            byte to uart_tx; stable from tx_start until tx_busy falls
// - tx_busy     in   1                 uart_tx is shifting (clk50 domain)
// - uart_cts    in   1                 clear-to-send from host, active-low, asynchronous
// - uart_rts    out  1                 request-to-send, active-low: low while any req_valid is set
// - grant_id    out  $clog2(NUM_REQ)   index of the last granted requester
// - arb_busy    out  1                 FSM is not in IDLE
// - timeout_err out  1                 sticky: tx_busy never rose
// - err_clr     in   1                 clears timeout_err
// BEHAVIOUR
// - Reset values, all outputs:
//   - req_ack=0, tx_start=0, tx_data=0, uart_rts=1, grant_id=0, arb_busy=0, timeout_err=0.
//   - Round-robin pointer = 0; FSM = IDLE.
// - uart_cts passes through a 2-flop synchroniser; cts_ok = ~cts_sync.
// - FSM states: IDLE -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
// - IDLE:
//   - When |req_valid and cts_ok, pick the first valid index at or after ptr, wrapping modulo NUM_REQ.
//   - Register sel and tx_data <= req_data[sel]; go to LOAD.
// - LOAD: req_ack[sel]=1 for this cycle only, grant_id<=sel; go to START.
// - START: tx_start=1 for exactly one cycle; clear timeout counter; go to WAIT_BUSY.
// - WAIT_BUSY:
//   - tx_busy=1 -> WAIT_DONE.
//   - Counter reaches BUSY_TIMEOUT-1 -> timeout_err<=1, go to IDLE, ptr<=sel+1. The byte is dropped, not retried.
// - WAIT_DONE: tx_busy=0 -> IDLE, ptr<=sel+1 (wrap at NUM_REQ).
// - Latency: valid with idle arbiter and cts_ok -> ack 2 cycles later -> tx_start 3 cycles later.
// - CTS is checked only in IDLE. CTS deasserting mid-byte never aborts a byte.
// - req_valid dropping after selection but before ack: the byte is still sent and acked. Requesters must not withdraw.
// - Simultaneous requests: the rotating pointer guarantees each requester waits at most NUM_REQ-1 bytes.
// - err_clr and a timeout in the same cycle: the timeout wins (timeout_err=1).
// - reset asserted mid-byte: immediate return to reset values; tx_start is never glitched high.
// - arb_busy = (state != IDLE).
// - uart_rts is registered: ~(|req_valid).
// CONFIGURATION
// - UART_TX_ARB_BURST_EN defined:
//   - In WAIT_DONE, if req_burst[sel] and req_valid[sel] and cts_ok and burst_cnt < MAX_BURST-1, go to LOAD without re-arbitrating.
//   - burst_cnt increments; ptr is not advanced.
//   - burst_cnt clears on each fresh IDLE grant.
//   - The burst ends on req_burst[sel]=0, on the MAX_BURST limit, or on CTS deassert.
// - Not defined: req_burst is ignored; every byte is re-arbitrated through IDLE.
// TESTING
// - Single byte: req_valid=4'b0001, data 0xA5, cts low, tx_busy model 10 cycles later.
//   -> ack[0] at +2, tx_start at +3 with tx_data=0xA5, arb_busy low after busy falls.
// - All four requesting continuously, bytes 0x10..0x13 -> grants 0,1,2,3,0 in order, one ack per byte.
// - cts_n held high with req pending -> no tx_start, uart_rts=0.
//   -> Release cts: tx_start within 5 cycles.
// - tx_busy stuck 0 after tx_start -> timeout_err=1 after 4096 cycles, FSM back in IDLE.
//   -> err_clr pulse clears it.
// - Reset pulled low during WAIT_DONE -> all outputs at reset values next edge, ptr=0.
// - Burst build: req 2 with req_burst=1 and 20 bytes queued, req 0 also valid.
//   -> 16 consecutive grants to 2, then grant to 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter: round-robin sharing of one UART transmitter with CTS gating,
// start/busy handshake and busy-timeout detection. Optional burst grants are
// enabled by defining UART_TX_ARB_BURST_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4096,
  parameter int MAX_BURST    = 16
) (
  input  logic                         clk50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_burst,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  input  logic                         uart_cts,
  output logic                         uart_rts,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy,
  output logic                         timeout_err,
  input  logic                         err_clr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel;
  logic [CNT_W-1:0]   busy_cnt;
  logic               cts_meta;
  logic               cts_sync;
  logic               cts_ok;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [IDX_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  int                 idx;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign cts_ok   = ~cts_sync;
  assign arb_busy = (state != IDLE);
  assign next_ptr = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  // Scan from the highest offset down so the first valid index at or after ptr wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

`ifdef UART_TX_ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST);
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_go;
  assign burst_go = req_burst[sel] && req_valid[sel] && cts_ok &&
                    (burst_cnt < BURST_W'(MAX_BURST-1));
`else
  logic burst_unused;
  assign burst_unused = ^{req_burst, MAX_BURST > 1};
`endif

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      sel         <= '0;
      busy_cnt    <= '0;
      tx_data     <= '0;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      uart_rts    <= 1'b1;
      timeout_err <= 1'b0;
      cts_meta    <= 1'b1;
      cts_sync    <= 1'b1;
`ifdef UART_TX_ARB_BURST_EN
      burst_cnt   <= '0;
`endif
    end else begin
      cts_meta <= uart_cts;
      cts_sync <= cts_meta;
      uart_rts <= ~(|req_valid);
      req_ack  <= '0;
      tx_start <= 1'b0;
      // A timeout assigned later in this block overrides the clear.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (found && cts_ok) begin
            sel     <= pick;
            tx_data <= req_bytes[pick];
            state   <= LOAD;
`ifdef UART_TX_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        LOAD: begin
          req_ack  <= NUM_REQ'(1) << sel;
          grant_id <= sel;
          state    <= START;
        end
        START: begin
          tx_start <= 1'b1;
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT-1)) begin
            timeout_err <= 1'b1;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef UART_TX_ARB_BURST_EN
            if (burst_go) begin
              burst_cnt <= burst_cnt + 1'b1;
              tx_data   <= req_bytes[sel];
              state     <= LOAD;
            end else begin
              ptr   <= next_ptr;
              state <= IDLE;
            end
`else
            ptr   <= next_ptr;
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
